// File: rtl/pwm_batch_preconditioner_pkg.sv
// rtl/pwm_batch_preconditioner_pkg.sv - shared types and output helper for the batch PWM engine
package pwm_pkg;

  localparam int PWM_WIDTH = 13;

  typedef struct packed {
    logic [PWM_WIDTH-1:0] left;
    logic [PWM_WIDTH-1:0] right;
    logic                 over;
    logic                 full;
    logic                 zero;
  } pwm_edge_t;

  typedef enum logic [1:0] {IDLE, CALC, PEND} calc_state_t;

  localparam pwm_edge_t EDGE_ZERO = '{left: '0, right: '0, over: 1'b0, full: 1'b0, zero: 1'b1};

  // A wrapped (over) window is high outside [right, left).
  function automatic logic pwm_level(input pwm_edge_t e, input logic [PWM_WIDTH-1:0] t);
    if (e.full) return 1'b1;
    if (e.zero) return 1'b0;
    if (e.over) return (t >= e.left) || (t < e.right);
    return (t >= e.left) && (t < e.right);
  endfunction

endpackage

// File: rtl/pwm_batch_preconditioner_if.sv
// rtl/pwm_batch_preconditioner_if.sv - control/driver bundle for the batch PWM engine
interface pwm_batch_preconditioner_if #(
  parameter int WIDTH = pwm_pkg::PWM_WIDTH,
  parameter int DEPTH = 249
);
  logic [WIDTH-1:0]            time_cnt;
  logic                        start;
  logic                        update;
  logic [WIDTH-1:0]            cycle;
  logic [DEPTH-1:0][WIDTH-1:0] duty;
  logic [DEPTH-1:0][WIDTH-1:0] phase;
  logic                        busy;
  logic                        pending;
  logic [DEPTH-1:0]            pwm_out;

  modport master (
    output time_cnt, start, update, cycle, duty, phase,
    input  busy, pending, pwm_out
  );

  modport slave (
    input  time_cnt, start, update, cycle, duty, phase,
    output busy, pending, pwm_out
  );
endinterface

// File: rtl/pwm_batch_preconditioner_edge_calc.sv
// rtl/pwm_batch_preconditioner_edge_calc.sv - two-stage edge pipeline: phase reduce/clamp, then wrap
module pwm_edge_calc
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [WIDTH-1:0] cycle,
  input  logic [WIDTH-1:0] duty,
  input  logic [WIDTH-1:0] phase,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output pwm_edge_t        out_edge
);

  logic [WIDTH:0] cyc_x, ph_x, p, half_lo, l_calc, r_calc;

  // Left edge is kept as a signed WIDTH+1 value so underflow shows in the top bit.
  always_comb begin
    cyc_x   = {1'b0, cycle};
    ph_x    = {1'b0, phase};
    half_lo = {2'b00, duty[WIDTH-1:1]};
    p       = (ph_x >= cyc_x) ? ph_x - cyc_x : ph_x;
    l_calc  = p - half_lo;
    r_calc  = p + ({1'b0, duty} - half_lo);
  end

  logic             s1_valid, s1_full, s1_zero;
  logic [IDX_W-1:0] s1_idx;
  logic [WIDTH:0]   s1_l, s1_r;

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    s1_idx  <= in_idx;
    s1_l    <= l_calc;
    s1_r    <= r_calc;
    s1_full <= (duty >= cycle);
    s1_zero <= (duty == '0) && (duty < cycle);
  end

  logic under, over_r;

  always_comb begin
    under          = s1_l[WIDTH];
    over_r         = (s1_r >= cyc_x);
    out_edge.left  = WIDTH'(under ? s1_l + cyc_x : s1_l);
    out_edge.right = WIDTH'(over_r ? s1_r - cyc_x : s1_r);
    out_edge.over  = under || over_r;
    out_edge.full  = s1_full;
    out_edge.zero  = s1_zero;
  end

  assign out_valid = s1_valid;
  assign out_idx   = s1_idx;

endmodule

// File: rtl/pwm_batch_preconditioner.sv
// rtl/pwm_batch_preconditioner.sv - multi-channel PWM with shared edge calculator and atomic bank commit
module pwm_batch_preconditioner
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH,
  parameter int DEPTH = 249
) (
  input logic                       clk,
  input logic                       rst,
  pwm_batch_preconditioner_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  calc_state_t                 state, state_nxt;
  logic                        capture, commit;
  logic [WIDTH-1:0]            cycle_s;
  logic [DEPTH-1:0][WIDTH-1:0] duty_s, phase_s;
  logic                        issue_en;
  logic [IDX_W-1:0]            idx;
  logic                        out_valid, wr_last;
  logic [IDX_W-1:0]            out_idx;
  pwm_edge_t                   out_edge;
  pwm_edge_t                   shadow [DEPTH];
  pwm_edge_t                   active [DEPTH];

  assign capture     = bus.update && (state != CALC);
  assign commit      = bus.start && (state == PEND);
  assign bus.busy    = (state == CALC);
  assign bus.pending = (state == PEND);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A START coinciding with a fresh UPDATE still commits; the FSM just heads back into CALC.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.update) state_nxt = CALC;
      CALC:    if (wr_last) state_nxt = PEND;
      PEND: begin
        if (bus.update)     state_nxt = CALC;
        else if (bus.start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && capture) begin
      cycle_s <= bus.cycle;
      duty_s  <= bus.duty;
      phase_s <= bus.phase;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_en <= 1'b0;
      idx      <= '0;
    end else if (capture) begin
      issue_en <= 1'b1;
      idx      <= '0;
    end else if (issue_en) begin
      if (idx == LAST_IDX) issue_en <= 1'b0;
      else                 idx      <= idx + 1'b1;
    end
  end

  pwm_edge_calc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_calc (
    .clk      (clk),
    .rst      (rst),
    .in_valid (issue_en),
    .in_idx   (idx),
    .cycle    (cycle_s),
    .duty     (duty_s[idx]),
    .phase    (phase_s[idx]),
    .out_valid(out_valid),
    .out_idx  (out_idx),
    .out_edge (out_edge)
  );

  always_ff @(posedge clk) begin
    if (rst) wr_last <= 1'b0;
    else     wr_last <= out_valid && (out_idx == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] <= EDGE_ZERO;
    end else if (out_valid) begin
      shadow[out_idx] <= out_edge;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) active[i] <= EDGE_ZERO;
    end else if (commit) begin
      for (int i = 0; i < DEPTH; i++) active[i] <= shadow[i];
    end
  end

  // On the commit edge the shadow bank drives the outputs so the new period starts clean at t=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pwm_out <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        bus.pwm_out[i] <= pwm_level(commit ? shadow[i] : active[i], bus.time_cnt);
    end
  end

endmodule

// File: tb/tb_pwm_batch_preconditioner.sv
// tb/tb_pwm_batch_preconditioner.sv - scoreboard bench for the batch PWM engine
module tb_pwm_batch_preconditioner;

  localparam int W = 13;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_batch_preconditioner_if #(.WIDTH(W), .DEPTH(D)) bus ();

  pwm_batch_preconditioner #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [D+1:0] expq[$];
  logic [D+1:0] mon_exp, mon_got;

  int act_d[D], act_p[D], sh_d[D], sh_p[D], st_d[D], st_p[D];
  int act_c = 2, sh_c = 2, st_c = 2;
  int period = 5000;
  int busy_cnt = 0;
  bit m_pend = 0;
  int cur_t = 0;

  // Pulse of width d centred on the reduced phase: high when t lies d slots past the left edge, modulo c.
  function automatic bit level(input int d, input int ph, input int c, input int t);
    int l;
    if (d >= c) return 1'b1;
    if (d == 0) return 1'b0;
    l = ((ph >= c) ? ph - c : ph) - d / 2;
    return ((((t - l) % c) + c) % c) < d;
  endfunction

  task automatic model_edge();
    logic [D-1:0] o;
    bit commit;
    int t;
    o = '0;
    t = int'(bus.time_cnt);
    if (rst) begin
      busy_cnt = 0;
      m_pend   = 0;
      for (int i = 0; i < D; i++) begin
        act_d[i] = 0;
        sh_d[i]  = 0;
      end
    end else begin
      commit = bus.start && m_pend;
      for (int i = 0; i < D; i++)
        o[i] = commit ? level(sh_d[i], sh_p[i], sh_c, t) : level(act_d[i], act_p[i], act_c, t);
      if (commit) begin
        for (int i = 0; i < D; i++) begin
          act_d[i] = sh_d[i];
          act_p[i] = sh_p[i];
        end
        act_c  = sh_c;
        period = sh_c;
        m_pend = 0;
      end
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          m_pend = 1;
          for (int i = 0; i < D; i++) begin
            sh_d[i] = st_d[i];
            sh_p[i] = st_p[i];
          end
          sh_c = st_c;
        end
      end else if (bus.update) begin
        st_c = int'(bus.cycle);
        for (int i = 0; i < D; i++) begin
          st_d[i] = int'(bus.duty[i]);
          st_p[i] = int'(bus.phase[i]);
        end
        m_pend   = 0;
        busy_cnt = D + 2;
      end
    end
    expq.push_back({busy_cnt > 0, m_pend, o});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    rst        = 1'b0;
    bus.update = 1'b0;
    cur_t        = (cur_t + 1 >= period) ? 0 : cur_t + 1;
    bus.time_cnt = W'(cur_t);
    bus.start    = (cur_t == 0);
    bus.cycle    = W'($urandom);
    for (int i = 0; i < D; i++) begin
      bus.duty[i]  = W'($urandom);
      bus.phase[i] = W'($urandom);
    end
  endtask

  task automatic do_update(input int c, input int d[D], input int p[D]);
    bus.cycle = W'(c);
    for (int i = 0; i < D; i++) begin
      bus.duty[i]  = W'(d[i]);
      bus.phase[i] = W'(p[i]);
    end
    bus.update = 1'b1;
    step();
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    while (cur_t != target && n < 20000) begin
      step();
      n++;
    end
    vectors++;
    if (cur_t != target) begin
      miscompares++;
      $display("FAIL run_to: t=%0d, required t=%0d", cur_t, target);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mon_exp = expq.pop_front();
      mon_got = {bus.busy, bus.pending, bus.pwm_out};
      vectors++;
      if (mon_got !== mon_exp)
        begin
          miscompares++;
          $display("FAIL busy_pend_out at %0t: got %b, expected %b", $time, mon_got, mon_exp);
        end
    end
  end

  int d1[D] = '{2500, 2500, 2500, 1};
  int p1[D] = '{2500, 1000, 4000, 0};
  int d2[D] = '{1, 2, 0, 5000};
  int p2[D] = '{1, 1, 123, 0};
  int d3[D] = '{6000, 4999, 2, 3};
  int p3[D] = '{7, 8191, 0, 5000};
  int rd[D], rp[D];
  int rc;

  initial begin
    rst          = 1'b1;
    bus.update   = 1'b0;
    bus.start    = 1'b1;
    bus.time_cnt = '0;
    bus.cycle    = '0;
    bus.duty     = '0;
    bus.phase    = '0;
    repeat (3) begin
      rst = 1'b1;
      step();
    end

    // directed waveforms; a second UPDATE while busy must be dropped
    run_to(100);
    do_update(5000, d1, p1);
    step();
    do_update(5000, d2, p2);
    run_to(100);
    do_update(5000, d2, p2);
    run_to(100);
    do_update(5000, d3, p3);
    run_to(100);
    run_to(99);

    // reset in the middle of a calculation: nothing may commit afterwards
    run_to(100);
    do_update(5000, d1, p1);
    step();
    step();
    rst = 1'b1;
    step();
    run_to(100);

    // PENDING rising on START defers commit; UPDATE on the commit edge is accepted
    run_to(4994);
    do_update(5000, d1, p1);
    run_to(0);
    step();
    run_to(0);
    do_update(5000, d2, p2);
    run_to(0);
    run_to(300);

    // randomized updates with short periods
    for (int k = 0; k < 60; k++) begin
      rc = $urandom_range(60, 2);
      for (int i = 0; i < D; i++) begin
        rd[i] = $urandom_range(rc + 3, 0);
        rp[i] = $urandom_range(2 * rc - 1, 0);
      end
      repeat ($urandom_range(2 * rc, 0)) step();
      if (k % 9 == 4) begin
        rst = 1'b1;
        step();
      end
      do_update(rc, rd, rp);
    end
    repeat (200) step();

    @(negedge clk);
    #1;
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
